// File: rtl/if_pkg.sv
// Types and constants shared by the IF1/IF2 boundary, IF2 and the BPU.
// Fetch groups are a base PC plus a per-lane valid mask.
package if_pkg;

    localparam int INST_BYTES = 4;
    localparam int DEF_LANES  = 2;
    localparam int DEF_PC_W   = 32;

    typedef struct packed {
        logic [DEF_PC_W-1:0]  pc;
        logic [DEF_LANES-1:0] mask;
    } fetch_grp_t;

endpackage

// File: rtl/if_grp_fifo.sv
// Generic DEPTH-entry synchronous FIFO of fetch groups with whole-queue flush.
// Occupancy count and pointers reset; entry storage does not.
module if_grp_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_grp_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    input  logic flush_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic           push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; validity comes only from count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/if_stage_queue.sv
// IF1->IF2 fetch-group queue: filters empty groups, buffers DEPTH groups,
// expands the head base PC into per-lane PCs and masks outputs on flush.
module if_stage_queue
    import if_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int PC_W  = DEF_PC_W,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [PC_W-1:0]       i_pc,
    input  logic [LANES-1:0]      i_lane_mask,
    output logic                  o_ready,
    input  logic                  i_flush,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [LANES*PC_W-1:0] o_pc,
    output logic [LANES-1:0]      o_lane_valid
);

    // Same layout as fetch_grp_t, sized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [LANES-1:0] mask;
    } grp_t;

    grp_t wr_grp, head_grp;
    logic push, pop, full, empty;

    assign wr_grp.pc   = i_pc;
    assign wr_grp.mask = i_lane_mask;

    assign o_ready      = ~full;
    assign push         = i_valid & o_ready & ~i_flush & (|i_lane_mask);
    assign o_valid      = ~empty & ~i_flush;
    assign pop          = o_valid & i_ready;
    assign o_lane_valid = head_grp.mask & {LANES{o_valid}};

    // Lane PCs wrap modulo 2^PC_W; the carry out is intentionally dropped.
    always_comb begin
        o_pc = '0;
        for (int k = 0; k < LANES; k++) begin
            o_pc[k*PC_W +: PC_W] = head_grp.pc + PC_W'(INST_BYTES * k);
        end
    end

    if_grp_fifo #(
        .DEPTH (DEPTH),
        .T     (grp_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (wr_grp),
        .pop_i   (pop),
        .flush_i (i_flush),
        .head_o  (head_grp),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule
